// File: rtl/spi_slave_byte_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave_byte_if                                          |
// | Description : SPI mode-0 slave byte front end. Oversamples SCK/CS_N/MOSI |
// |               in the clk domain, deserialises MOSI into bytes with a     |
// |               one-cycle rx_valid strobe and serialises a pending tx      |
// |               byte (or IDLE_BYTE) onto MISO in the next byte slot.       |
// |               Optional macro SPI_TX_UNDERRUN_EN adds a sticky            |
// |               tx_underrun flag output.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_slave_byte_if #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       frame_active
`ifdef SPI_TX_UNDERRUN_EN
  , output logic     tx_underrun
`endif
);

  // Cycles after reset until the synchroniser outputs reflect the real pins.
  localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_pipe, cs_pipe, mosi_pipe;
  logic       sck_hist, cs_hist;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;
  logic [2:0] settle_cnt;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] pend_data;
  logic       pend_vld;
  logic       start_load, bnd_load, rx_step, tx_step, bit_clr;
  logic       any_load;

  assign sck_s  = sck_pipe[SYNC_STAGES-1];
  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign cs_fall  = ~cs_s & cs_hist;
  assign cs_rise  = cs_s & ~cs_hist;

  assign any_load     = start_load | bnd_load;
  assign spi_miso     = tx_shift[7];
  assign frame_active = (state == ST_FRAME);

  // Pin synchronisers plus one history flop on sck and cs_n for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_pipe  <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      sck_hist  <= sck_s;
      cs_hist   <= cs_s;
    end
  end

  // Arm frame start only once CS has been seen genuinely high after reset, so a
  // reset released mid-frame cannot fake a cs_fall from the idle reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 3'd0;
      armed      <= 1'b0;
    end else if (settle_cnt != SETTLE_CYCLES) begin
      settle_cnt <= settle_cnt + 3'd1;
    end else if (cs_s) begin
      armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and per-cycle datapath controls.
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    bnd_load   = 1'b0;
    rx_step    = 1'b0;
    tx_step    = 1'b0;
    bit_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall && armed) begin
          state_nxt  = ST_FRAME;
          start_load = 1'b1;
        end
      end
      ST_FRAME: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          bit_clr   = 1'b1;
        end else begin
          rx_step = sck_rise;
          if (sck_fall) begin
            if (bit_cnt == 3'd0) bnd_load = 1'b1;
            else                 tx_step  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Receive path: bit counter, MOSI deserialiser and rx strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_load || bit_clr) begin
        bit_cnt <= 3'd0;
      end else if (rx_step) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Transmit path: pending buffer and MISO shifter. A tx_valid that lands on a
  // load cycle bypasses the buffer so the byte is not delayed by one slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift  <= IDLE_BYTE;
      pend_data <= 8'd0;
      pend_vld  <= 1'b0;
    end else if (any_load) begin
      pend_vld <= 1'b0;
      if (tx_valid)      tx_shift <= tx_data;
      else if (pend_vld) tx_shift <= pend_data;
      else               tx_shift <= IDLE_BYTE;
    end else begin
      if (tx_valid) begin
        pend_data <= tx_data;
        pend_vld  <= 1'b1;
      end
      if (tx_step) tx_shift <= {tx_shift[6:0], 1'b1};
    end
  end

`ifdef SPI_TX_UNDERRUN_EN
  // Sticky flag: a byte slot began with nothing to send and fell back to IDLE_BYTE.
  always_ff @(posedge clk) begin
    if (rst)                                    tx_underrun <= 1'b0;
    else if (any_load && !tx_valid && !pend_vld) tx_underrun <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_byte_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_slave_byte_if                                       |
// | Description : Scoreboard bench for spi_slave_byte_if. An SPI master task  |
// |               drives frames; expected rx bytes are queued at issue time  |
// |               and popped by a monitor on rx_valid. MISO bytes are checked |
// |               against a slot model of the pending tx buffer.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_slave_byte_if;

  localparam int         HALF = 4;       // SCK half period in clk cycles (fSCK = fclk/8)
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst, sck, cs_n, mosi, miso, rx_valid, tx_valid, frame_active;
  logic [7:0] rx_data, tx_data;
`ifdef SPI_TX_UNDERRUN_EN
  logic       tx_underrun;
`endif

  spi_slave_byte_if #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (sck),
    .spi_cs_n     (cs_n),
    .spi_mosi     (mosi),
    .spi_miso     (miso),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .frame_active (frame_active)
`ifdef SPI_TX_UNDERRUN_EN
    , .tx_underrun(tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queue of bytes the master has sent in full.
  logic [7:0] rx_q[$];

  // Model of the tx side: one pending byte, consumed at the start of each slot.
  logic [7:0] m_pend;
  bit         m_pend_vld;
  bit         m_under;

  // Frame description consumed by run_frame.
  int         f_n;
  logic [7:0] f_bytes[4];
  logic [8:0] f_end[4];     // bit 8: issue tx_valid after that byte's 8th rise
  bit         f_mid_en;
  logic [7:0] f_mid;
  bit         f_pre_en;
  logic [7:0] f_pre;
  int         f_abort;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid   = 1'b0;
    m_pend     = d;
    m_pend_vld = 1'b1;
  endtask

  function automatic logic [7:0] slot_load();
    if (m_pend_vld) begin
      m_pend_vld = 1'b0;
      return m_pend;
    end
    m_under = 1'b1;
    return IDLE;
  endfunction

  // Shift nbits out MSB first; MISO is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] b, input int nbits,
                      input bit mid_en, input logic [7:0] mid_d,
                      input bit end_en, input logic [7:0] end_d,
                      output logic [7:0] got);
    got = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      clks(HALF);
      got = {got[6:0], miso};
      sck = 1'b1;
      if (i == 3 && mid_en) begin
        clks(1); pulse_tx(mid_d); clks(HALF-2);
      end else if (i == 7 && end_en) begin
        clks(2); pulse_tx(end_d); clks(HALF-3);
      end else begin
        clks(HALF);
      end
      sck = 1'b0;
    end
  endtask

  task automatic run_frame();
    logic [7:0] slot, got;
    if (f_pre_en) pulse_tx(f_pre);
    cs_n = 1'b0;
    slot = slot_load();
    clks(6);
    check("frame_active_in_frame", 32'(frame_active), 32'd1);
    for (int i = 0; i < f_n; i++) begin
      rx_q.push_back(f_bytes[i]);
      xfer(f_bytes[i], 8, f_mid_en && (i == 0), f_mid, f_end[i][8], f_end[i][7:0], got);
      check("miso_byte", 32'(got), 32'(slot));
      slot = slot_load();
    end
    if (f_abort > 0) xfer(8'($urandom), f_abort, 1'b0, 8'd0, 1'b0, 8'd0, got);
    clks(4);
    cs_n = 1'b1;
    clks(6);
    check("frame_active_after_cs", 32'(frame_active), 32'd0);
`ifdef SPI_TX_UNDERRUN_EN
    check("tx_underrun", 32'(tx_underrun), 32'(m_under));
`endif
  endtask

  task automatic clear_frame();
    f_n = 0; f_mid_en = 1'b0; f_mid = 8'd0; f_pre_en = 1'b0; f_pre = 8'd0; f_abort = 0;
    for (int j = 0; j < 4; j++) begin
      f_bytes[j] = 8'd0;
      f_end[j]   = 9'd0;
    end
  endtask

  // Monitor: every rx_valid pops one expected byte; a pulse wider than 1 clk is an error.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_valid_width", 32'(prev_v), 32'd0);
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_unexpected: actual rx_valid with rx_data %0h, required no rx_valid", rx_data);
      end else begin
        check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
    prev_v = rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] dummy;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'd0;
    m_pend = 8'd0; m_pend_vld = 1'b0; m_under = 1'b0;
    clear_frame();
    clks(4);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_miso", 32'(miso), 32'(IDLE[7]));
    check("rst_frame_active", 32'(frame_active), 32'd0);
`ifdef SPI_TX_UNDERRUN_EN
    check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
`endif
    rst = 1'b0;
    clks(6);

    // Two bytes back to back, no tx data.
    clear_frame(); f_n = 2; f_bytes[0] = 8'h87; f_bytes[1] = 8'h5A;
    run_frame();

    // Byte queued before the frame, then a frame that must fall back to idle.
    clear_frame(); f_n = 1; f_bytes[0] = 8'h3E; f_pre_en = 1'b1; f_pre = 8'hC3;
    run_frame();
    clear_frame(); f_n = 1; f_bytes[0] = 8'h01;
    run_frame();

    // Reply byte supplied right after the first byte completes.
    clear_frame(); f_n = 2; f_bytes[0] = 8'h96; f_bytes[1] = 8'h69; f_end[0] = {1'b1, 8'h3C};
    run_frame();

    // Partial byte aborted by CS, then a clean byte.
    clear_frame(); f_abort = 5;
    run_frame();
    clear_frame(); f_n = 1; f_bytes[0] = 8'hA5;
    run_frame();

    // Reset mid-frame with CS held low and SCK toggling.
    m_pend = 8'd0;
    cs_n = 1'b0;
    dummy = slot_load();
    clks(6);
    xfer(8'hFF, 3, 1'b0, 8'd0, 1'b0, 8'd0, dummy);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    m_pend_vld = 1'b0;
    m_under = 1'b0;
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    check("rst_mid_miso", 32'(miso), 32'(IDLE[7]));
    xfer(8'hC7, 8, 1'b0, 8'd0, 1'b0, 8'd0, dummy);
    xfer(8'h3B, 8, 1'b0, 8'd0, 1'b0, 8'd0, dummy);
    check("rst_mid_frame_active", 32'(frame_active), 32'd0);
    cs_n = 1'b1;
    clks(6);
    clear_frame(); f_n = 1; f_bytes[0] = 8'h12;
    run_frame();

    // Pending byte overwritten before the boundary.
    clear_frame(); f_n = 2; f_bytes[0] = 8'h55; f_bytes[1] = 8'hAA;
    f_mid_en = 1'b1; f_mid = 8'h11; f_end[0] = {1'b1, 8'h22};
    run_frame();

    // Randomised frames.
    for (int k = 0; k < 40; k++) begin
      clear_frame();
      f_n = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) begin
        f_bytes[j] = 8'($urandom);
        f_end[j]   = {1'($urandom_range(0, 1)), 8'($urandom)};
      end
      f_mid_en = ($urandom_range(0, 9) < 3) && (f_n > 0);
      f_mid    = 8'($urandom);
      f_pre_en = ($urandom_range(0, 9) < 3);
      f_pre    = 8'($urandom);
      f_abort  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_frame();
    end

    clks(20);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
